// File: rtl/md_seq_ctrl.sv
// Multi-cycle sequencer for RV32M mul/div/rem: stalls execute for a per-class
// latency, pulses start to the datapath and strobes a single write-back.
module md_seq_ctrl #(
  parameter int unsigned MUL_LAT = 3,
  parameter int unsigned DIV_LAT = 33,
  parameter int unsigned CNT_W   = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       valid_in,
  input  logic [4:0] alu_ctl,
  input  logic [4:0] rd_in,
  input  logic       div_zero,
  input  logic       flush,
  output logic       start_o,
  output logic [4:0] op_o,
  output logic       stall_o,
  output logic       busy_o,
  output logic       wb_valid_o,
  output logic       reg_wr_o,
  output logic [4:0] rd_o,
  output logic       dz_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             is_md;
  logic             is_div;
  logic             dz_path;
  logic             accept;

  assign is_md   = (alu_ctl >= 5'd2) && (alu_ctl <= 5'd9);
  assign is_div  = (alu_ctl >= 5'd6) && (alu_ctl <= 5'd9);
  assign dz_path = is_div & div_zero;

  // Gated by rst_n so no stall or accept is seen while reset is held.
  assign accept = rst_n & (state == S_IDLE) & valid_in & is_md & ~flush;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (flush) begin
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (dz_path) begin
              state_nxt = S_DONE;
              cnt_nxt   = '0;
            end else begin
              state_nxt = S_BUSY;
              cnt_nxt   = is_div ? DIV_LOAD : MUL_LOAD;
            end
          end
        end
        S_BUSY: begin
          if (cnt == '0) begin
            state_nxt = S_DONE;
          end else begin
            cnt_nxt = cnt - 1'b1;
          end
        end
        S_DONE: begin
          state_nxt = S_IDLE;
        end
        default: begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      start_o <= 1'b0;
      op_o    <= '0;
      rd_o    <= '0;
      dz_o    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      start_o <= accept;
      if (accept) begin
        op_o <= alu_ctl;
        rd_o <= rd_in;
        dz_o <= dz_path;
      end
    end
  end

  assign busy_o     = (state == S_BUSY);
  assign stall_o    = accept | busy_o;
  assign wb_valid_o = rst_n & (state == S_DONE) & ~flush;
  assign reg_wr_o   = wb_valid_o & (rd_o != 5'd0);

endmodule

// File: tb/tb_md_seq_ctrl.sv
// Directed bench for md_seq_ctrl: latency, divide-by-zero, flush, reset and
// back-to-back behaviour with hand-derived per-cycle expectations.
module tb_md_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid_in;
  logic [4:0] alu_ctl;
  logic [4:0] rd_in;
  logic       div_zero;
  logic       flush;
  logic       start_o;
  logic [4:0] op_o;
  logic       stall_o;
  logic       busy_o;
  logic       wb_valid_o;
  logic       reg_wr_o;
  logic [4:0] rd_o;
  logic       dz_o;

  int n_cmp = 0;
  int n_err = 0;

  md_seq_ctrl #(.MUL_LAT(3), .DIV_LAT(33), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .alu_ctl(alu_ctl),
    .rd_in(rd_in), .div_zero(div_zero), .flush(flush), .start_o(start_o),
    .op_o(op_o), .stall_o(stall_o), .busy_o(busy_o), .wb_valid_o(wb_valid_o),
    .reg_wr_o(reg_wr_o), .rd_o(rd_o), .dz_o(dz_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  // Inputs change 1 time unit after the edge; checks happen 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; valid_in = 1'b1; alu_ctl = 5'd2; rd_in = 5'd5;
    div_zero = 1'b0; flush = 1'b0;
    tick();
    #1;
    n_cmp++;
    if ({start_o, op_o, stall_o, busy_o, wb_valid_o, reg_wr_o, rd_o, dz_o} !== 16'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h required 0000",
               {start_o, op_o, stall_o, busy_o, wb_valid_o, reg_wr_o, rd_o, dz_o});
    end
    tick();
    #1;
    n_cmp++;
    if ({stall_o, start_o, busy_o} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_no_accept: got %b required 000", {stall_o, start_o, busy_o});
    end
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (stall_o !== 1'b1) begin
      n_err++;
      $display("FAIL reset_first_accept stall: got %b required 1", stall_o);
    end
    tick();
    valid_in = 1'b0;
    #1;
    n_cmp++;
    if ({start_o, busy_o, op_o, rd_o} !== {1'b1, 1'b1, 5'd2, 5'd5}) begin
      n_err++;
      $display("FAIL reset_first_start: got %b required %b",
               {start_o, busy_o, op_o, rd_o}, {1'b1, 1'b1, 5'd2, 5'd5});
    end
    for (int i = 0; i < 5; i++) tick();
  endtask

  // lat = 0 selects the divide-by-zero fast path.
  task automatic test_op(input string name, input logic [4:0] ctl, input logic [4:0] rd,
                         input logic dz, input int lat, input logic exp_dz);
    logic [4:0]  exp_v;
    logic [4:0]  got_v;
    logic [10:0] exp_l;
    valid_in = 1'b1; alu_ctl = ctl; rd_in = rd; div_zero = dz;
    for (int c = 0; c <= lat + 2; c++) begin
      #1;
      exp_v = {c <= lat, c == 1, (c >= 1) && (c <= lat), c == lat + 1,
               (c == lat + 1) && (rd != 5'd0)};
      got_v = {stall_o, start_o, busy_o, wb_valid_o, reg_wr_o};
      n_cmp++;
      if (got_v !== exp_v) begin
        n_err++;
        $display("FAIL %s ctl c=%0d: got stall/start/busy/wb/wr=%b required %b",
                 name, c, got_v, exp_v);
      end
      if (c >= 1) begin
        exp_l = {ctl, rd, exp_dz};
        n_cmp++;
        if ({op_o, rd_o, dz_o} !== exp_l) begin
          n_err++;
          $display("FAIL %s latch c=%0d: got op/rd/dz=%b required %b",
                   name, c, {op_o, rd_o, dz_o}, exp_l);
        end
      end
      tick();
      if (c == 0) begin
        valid_in = 1'b0;
        div_zero = 1'b0;
      end
    end
  endtask

  task automatic test_reset_abort();
    int wb_seen = 0;
    valid_in = 1'b1; alu_ctl = 5'd6; rd_in = 5'd11; div_zero = 1'b0;
    tick();
    valid_in = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if ({busy_o, op_o, rd_o, dz_o} !== 12'h0) begin
      n_err++;
      $display("FAIL reset_abort_state: got %b required 0", {busy_o, op_o, rd_o, dz_o});
    end
    for (int i = 0; i < 40; i++) begin
      if (wb_valid_o !== 1'b0) wb_seen++;
      tick();
    end
    n_cmp++;
    if (wb_seen != 0) begin
      n_err++;
      $display("FAIL reset_abort_wb: got %0d strobes required 0", wb_seen);
    end
  endtask

  task automatic test_flush_busy();
    int wb_seen = 0;
    valid_in = 1'b1; alu_ctl = 5'd6; rd_in = 5'd12; div_zero = 1'b0;
    tick();
    valid_in = 1'b0;
    tick();
    flush = 1'b1;
    #1;
    n_cmp++;
    if ({busy_o, stall_o} !== 2'b11) begin
      n_err++;
      $display("FAIL flush_busy_before: got busy/stall=%b required 11", {busy_o, stall_o});
    end
    tick();
    flush = 1'b0;
    #1;
    n_cmp++;
    if ({busy_o, stall_o, start_o, rd_o, op_o} !== {3'b000, 5'd12, 5'd6}) begin
      n_err++;
      $display("FAIL flush_busy_after: got %b required %b",
               {busy_o, stall_o, start_o, rd_o, op_o}, {3'b000, 5'd12, 5'd6});
    end
    for (int i = 0; i < 40; i++) begin
      if (wb_valid_o !== 1'b0 || busy_o !== 1'b0) wb_seen++;
      tick();
    end
    n_cmp++;
    if (wb_seen != 0) begin
      n_err++;
      $display("FAIL flush_busy_wb: got %0d active cycles required 0", wb_seen);
    end
  endtask

  task automatic test_flush_done();
    valid_in = 1'b1; alu_ctl = 5'd4; rd_in = 5'd20; div_zero = 1'b0;
    tick();
    valid_in = 1'b0;
    tick(); tick(); tick();
    flush = 1'b1;
    #1;
    n_cmp++;
    if ({wb_valid_o, reg_wr_o, busy_o, stall_o} !== 4'b0000) begin
      n_err++;
      $display("FAIL flush_done: got wb/wr/busy/stall=%b required 0000",
               {wb_valid_o, reg_wr_o, busy_o, stall_o});
    end
    tick();
    flush = 1'b0;
    #1;
    n_cmp++;
    if ({wb_valid_o, busy_o, rd_o} !== {2'b00, 5'd20}) begin
      n_err++;
      $display("FAIL flush_done_after: got %b required %b", {wb_valid_o, busy_o, rd_o},
               {2'b00, 5'd20});
    end
  endtask

  task automatic test_flush_accept();
    valid_in = 1'b1; alu_ctl = 5'd9; rd_in = 5'd1; div_zero = 1'b0; flush = 1'b1;
    #1;
    n_cmp++;
    if (stall_o !== 1'b0) begin
      n_err++;
      $display("FAIL flush_accept_stall: got %b required 0", stall_o);
    end
    tick();
    valid_in = 1'b0; flush = 1'b0;
    #1;
    n_cmp++;
    if ({start_o, busy_o, op_o, rd_o} !== {2'b00, 5'd4, 5'd20}) begin
      n_err++;
      $display("FAIL flush_accept_after: got %b required %b", {start_o, busy_o, op_o, rd_o},
               {2'b00, 5'd4, 5'd20});
    end
    tick();
  endtask

  task automatic test_non_md();
    logic [4:0] codes [4] = '{5'd0, 5'd1, 5'd10, 5'd31};
    foreach (codes[i]) begin
      valid_in = 1'b1; alu_ctl = codes[i]; rd_in = 5'd3;
      #1;
      n_cmp++;
      if (stall_o !== 1'b0) begin
        n_err++;
        $display("FAIL non_md_stall code=%0d: got %b required 0", codes[i], stall_o);
      end
      tick();
      #1;
      n_cmp++;
      if ({start_o, busy_o, wb_valid_o} !== 3'b000) begin
        n_err++;
        $display("FAIL non_md_state code=%0d: got %b required 000", codes[i],
                 {start_o, busy_o, wb_valid_o});
      end
    end
    valid_in = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [4:0] exp_v;
    logic [4:0] got_v;
    valid_in = 1'b1; alu_ctl = 5'd2; rd_in = 5'd3; div_zero = 1'b0;
    for (int c = 0; c <= 10; c++) begin
      #1;
      exp_v = {(c <= 3) || (c >= 5 && c <= 8), c == 1 || c == 6,
               (c >= 1 && c <= 3) || (c >= 6 && c <= 8), c == 4 || c == 9, c == 4 || c == 9};
      got_v = {stall_o, start_o, busy_o, wb_valid_o, reg_wr_o};
      n_cmp++;
      if (got_v !== exp_v) begin
        n_err++;
        $display("FAIL b2b ctl c=%0d: got stall/start/busy/wb/wr=%b required %b", c, got_v, exp_v);
      end
      if (c == 4 || c == 9) begin
        n_cmp++;
        if ({op_o, rd_o} !== ((c == 4) ? {5'd2, 5'd3} : {5'd5, 5'd9})) begin
          n_err++;
          $display("FAIL b2b wb c=%0d: got op/rd=%b required %b", c, {op_o, rd_o},
                   ((c == 4) ? {5'd2, 5'd3} : {5'd5, 5'd9}));
        end
      end
      tick();
      if (c == 3) begin
        alu_ctl = 5'd5; rd_in = 5'd9;
      end
      if (c == 5) valid_in = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_op("mul", 5'd2, 5'd7, 1'b0, 3, 1'b0);
    test_op("divu_x0", 5'd7, 5'd0, 1'b0, 33, 1'b0);
    test_op("rem_dz", 5'd8, 5'd15, 1'b1, 0, 1'b1);
    test_op("mulh_dz", 5'd3, 5'd16, 1'b1, 3, 1'b0);
    test_op("remu", 5'd9, 5'd31, 1'b0, 33, 1'b0);
    test_reset_abort();
    test_flush_busy();
    test_flush_done();
    test_flush_accept();
    test_non_md();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/md_seq_ctrl.md
Name: md_seq_ctrl

Overview:
- Multi-cycle sequencer for RV32M mul/div/rem operations, sitting beside the combinational control decoder in the execute stage.
- Accepts a decoded ALU control code.
- Stalls the pipeline for a parametrised latency, pulses start to the mul/div datapath, and issues a one-cycle write-back strobe with latched destination register.
- Supports per-class latency, a divide-by-zero fast path, and flush abort.

Parameters:
- MUL_LAT, 3: busy cycles for mul/mulh/mulsu/mulu (codes 5'd2-5'd5); must be >= 1.
- DIV_LAT, 33: busy cycles for div/divu/rem/remu (codes 5'd6-5'd9); must be >= 1.
- CNT_W, 6: counter width; must satisfy 2^CNT_W > max(MUL_LAT, DIV_LAT).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- valid_in  in  1  decoded instruction present in execute
- alu_ctl  in  5  ALU control code from decoder
- rd_in  in  5  destination register of incoming instruction
- div_zero  in  1  divisor (rs2) == 0, sampled at accept
- flush  in  1  pipeline flush (branch/jump redirect)
- start_o  out  1  one-cycle start pulse to mul/div datapath
- op_o  out  5  latched alu_ctl of in-flight op
- stall_o  out  1  hold PC and IF/ID/EX registers
- busy_o  out  1  state is BUSY
- wb_valid_o  out  1  one-cycle result-valid strobe
- reg_wr_o  out  1  register-file write enable for result
- rd_o  out  5  latched destination register
- dz_o  out  1  in-flight op took divide-by-zero path (datapath selects spec result)

Behaviour:
- Reset: rst_n low at a clk edge -> state IDLE, cnt=0; op_o, rd_o, dz_o = 0; start_o, busy_o, wb_valid_o, reg_wr_o = 0. Reset overrides any in-flight op; no write-back is issued for it.
- is_md = alu_ctl in 2..9; is_div = alu_ctl in 6..9. Other codes are never accepted.
- accept = (state==IDLE) & valid_in & is_md & ~flush, evaluated combinationally.
- States: IDLE, BUSY, DONE.
- IDLE:
  - On accept: latch op_o <= alu_ctl, rd_o <= rd_in, dz_o <= is_div & div_zero. start_o is a registered pulse for the cycle after accept.
  - If is_div & div_zero: -> DONE.
  - Else: cnt <= (is_div ? DIV_LAT : MUL_LAT) - 1; -> BUSY.
- BUSY: cnt==0 -> DONE, else cnt <= cnt-1. Occupies exactly LAT cycles.
- DONE: wb_valid_o=1 and reg_wr_o=(rd_o!=0), combinational from state, for exactly one cycle; -> IDLE unconditionally. valid_in is ignored in DONE.
- stall_o = accept | (state==BUSY), combinational.
  - stall_o is low in DONE, so the pipeline advances as the result is written.
  - Back-to-back md ops: the second is accepted the cycle after DONE.
- Timing, accept at cycle T:
  - normal: stall_o high T..T+LAT; wb_valid_o at T+LAT+1.
  - divide-by-zero: stall_o high at T only; wb_valid_o at T+1; no BUSY cycles. start_o still pulses at T+1 and the datapath ignores it when dz_o=1.
- busy_o = (state==BUSY).
- Flush:
  - In any state: next state IDLE, cnt=0, start_o not generated for an accept in that cycle.
  - Flush in DONE suppresses wb_valid_o and reg_wr_o in that cycle.
  - Flush in BUSY aborts silently.
  - op_o and rd_o hold their last values.
- Priority: rst_n > flush > FSM transitions.
- Counter never wraps: cnt is loaded only on accept and stops at 0.

Test Plan:
- Reset: rst_n=0 for 2 cycles with valid_in=1, alu_ctl=5'd2 -> all outputs 0 and no accept; first accept occurs only after rst_n=1.
- Mul latency: MUL_LAT=3; accept mul (alu_ctl=5'd2, rd_in=5'd7) at T -> stall_o=1 at T..T+3, start_o=1 at T+1 only, wb_valid_o=reg_wr_o=1 at T+4, rd_o=7, op_o=2.
- Div latency and rd=x0: DIV_LAT=33; divu (5'd7) with rd_in=0 -> wb_valid_o at T+34, reg_wr_o=0 throughout.
- Divide-by-zero: rem (5'd8), div_zero=1 -> dz_o=1, wb_valid_o at T+1, stall_o high only at T. Repeat with mul (5'd3), div_zero=1 -> normal MUL_LAT path, dz_o=0.
- Flush: flush at T+2 of a div -> IDLE at T+3, no wb_valid_o ever. Flush coinciding with DONE -> wb_valid_o=0. Flush in the same cycle as valid_in&is_md -> no accept, no start_o, stall_o=0.
- Non-md and back-to-back: alu_ctl=5'd0/5'd10 with valid_in=1 -> stall_o stays 0. Two consecutive muls -> second accepted at cycle after first DONE; two distinct wb_valid_o pulses with correct rd_o each.
